// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller. Sends EX/MEM loads and stores to a
// handshaked data memory, stalls upstream while an access is outstanding,
// and registers the MEM/WB payload for the write-back stage.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   PC_in .. Rd_in               EX/MEM register contents
//   mem_req/we/addr/wdata        registered memory request (held until ack/timeout)
//   mem_rdata, mem_ack           memory response (ack is a one-cycle pulse)
//   stall                        combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   PC_out .. Rd_out             MEM/WB register contents
//   mem_err                      one-cycle pulse with the WB load of a faulted access
module mem_stage_ctrl #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   input  logic [31:0] ALU_output_in,
   input  logic [31:0] Write_data_in,
   input  logic [4:0]  Rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic [31:0] PC_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic [31:0] ALU_output_out,
   output logic [31:0] Read_data_out,
   output logic [4:0]  Rd_out,
   output logic        mem_err
);

   localparam int unsigned CNT_W     = $clog2(MAX_WAIT) + 1;
   localparam logic [31:0] BUBBLE_PC = 32'hffff_ffff;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic [31:0]      rdata_q, rdata_d;

   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic [31:0] pc_q, pc_d;
   logic        m2r_q, m2r_d;
   logic        rw_q, rw_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] rdd_q, rdd_d;
   logic [4:0]  rd_q, rd_d;
   logic        err_q, err_d;

   logic access_c, aligned_c, start_c, timeout_c, stall_c;

   assign access_c  = MemRead_in | MemWrite_in;
   assign aligned_c = (ALU_output_in[1:0] == 2'b00);
   assign start_c   = access_c & aligned_c;
   assign timeout_c = (cnt_q == CNT_W'(MAX_WAIT - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; an ack beats a same-cycle timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_c) state_d = S_WAIT;
         S_WAIT:  if (mem_ack || timeout_c) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      stall_c     = 1'b0;
      cnt_d       = cnt_q;
      fault_d     = fault_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      pc_d        = PC_in;
      m2r_d       = MemtoReg_in;
      rw_d        = RegWrite_in;
      alu_d       = ALU_output_in;
      rdd_d       = 32'h0;
      rd_d        = Rd_in;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               stall_c     = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = MemWrite_in;
               mem_addr_d  = ALU_output_in;
               mem_wdata_d = Write_data_in;
               cnt_d       = '0;
               fault_d     = 1'b0;
               rdata_d     = 32'h0;
            end else if (access_c) begin
               // Misaligned: no request, suppress write-back, flag error
               rw_d  = 1'b0;
               err_d = 1'b1;
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (mem_ack) begin
               mem_req_d = 1'b0;
               rdata_d   = mem_we_q ? 32'h0 : mem_rdata;
            end else if (timeout_c) begin
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
            end
         end
         S_DONE: begin
            rw_d  = RegWrite_in & ~fault_q;
            rdd_d = fault_q ? 32'h0 : rdata_q;
            err_d = fault_q;
         end
         default: ;
      endcase
      // Bubble into MEM/WB while upstream is frozen, preventing duplicate write-backs
      if (stall_c) begin
         pc_d  = BUBBLE_PC;
         m2r_d = 1'b0;
         rw_d  = 1'b0;
         alu_d = 32'h0;
         rdd_d = 32'h0;
         rd_d  = 5'd0;
         err_d = 1'b0;
      end
   end

   // Request, bookkeeping and MEM/WB registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         fault_q     <= 1'b0;
         rdata_q     <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         pc_q        <= BUBBLE_PC;
         m2r_q       <= 1'b0;
         rw_q        <= 1'b0;
         alu_q       <= 32'h0;
         rdd_q       <= 32'h0;
         rd_q        <= 5'd0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         fault_q     <= fault_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         pc_q        <= pc_d;
         m2r_q       <= m2r_d;
         rw_q        <= rw_d;
         alu_q       <= alu_d;
         rdd_q       <= rdd_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
      end
   end

   assign stall          = stall_c & ~rst;
   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign PC_out         = pc_q;
   assign MemtoReg_out   = m2r_q;
   assign RegWrite_out   = rw_q;
   assign ALU_output_out = alu_q;
   assign Read_data_out  = rdd_q;
   assign Rd_out         = rd_q;
   assign mem_err        = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed and randomized instructions checked
// against a per-instruction expectation model.
module tb_mem_stage_ctrl;

   localparam int unsigned MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC_in;
   logic        MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
   logic [31:0] ALU_output_in, Write_data_in;
   logic [4:0]  Rd_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack, stall;
   logic [31:0] PC_out;
   logic        MemtoReg_out, RegWrite_out;
   logic [31:0] ALU_output_out, Read_data_out;
   logic [4:0]  Rd_out;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        m2r;
      logic        rw;
      logic [31:0] alu;
      logic [31:0] rdd;
      logic [4:0]  rd;
      logic        err;
   } wb_t;

   wb_t pend;

   mem_stage_ctrl #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .PC_in(PC_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
      .ALU_output_in(ALU_output_in), .Write_data_in(Write_data_in), .Rd_in(Rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .PC_out(PC_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
      .ALU_output_out(ALU_output_out), .Read_data_out(Read_data_out),
      .Rd_out(Rd_out), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag, input wb_t e);
      chk({tag, ".pc"},  PC_out, e.pc);
      chk({tag, ".m2r"}, 32'(MemtoReg_out), 32'(e.m2r));
      chk({tag, ".rw"},  32'(RegWrite_out), 32'(e.rw));
      chk({tag, ".alu"}, ALU_output_out, e.alu);
      chk({tag, ".rdd"}, Read_data_out, e.rdd);
      chk({tag, ".rd"},  32'(Rd_out), 32'(e.rd));
      chk({tag, ".err"}, 32'(mem_err), 32'(e.err));
   endtask

   task automatic chk_bubble(input string tag);
      wb_t b;
      b.pc = 32'hffff_ffff; b.m2r = 1'b0; b.rw = 1'b0; b.alu = 32'h0;
      b.rdd = 32'h0; b.rd = 5'd0; b.err = 1'b0;
      chk_wb(tag, b);
   endtask

   // One instruction held in EX/MEM until the stage releases it.
   // ack_at: WAIT cycle (1..MW) on which memory acks; anything else = never.
   task automatic run_instr(input logic [31:0] pc, input logic [4:0] rd,
                            input logic mr, input logic mw, input logic m2r, input logic rw,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_at);
      logic acc, al, fault;
      int   nw;
      acc = mr | mw;
      al  = (alu[1:0] == 2'b00);
      @(posedge clk); #1;
      PC_in = pc; Rd_in = rd; MemRead_in = mr; MemWrite_in = mw;
      MemtoReg_in = m2r; RegWrite_in = rw; ALU_output_in = alu; Write_data_in = wd;
      mem_ack = 1'($urandom % 2);       // spurious in IDLE
      mem_rdata = $urandom;
      @(negedge clk);
      chk_wb("wb", pend);
      chk("req_idle", 32'(mem_req), 32'h0);
      if (!acc || !al) begin
         chk("stall_nomem", 32'(stall), 32'h0);
         pend.pc = pc; pend.m2r = m2r; pend.rw = acc ? 1'b0 : rw; pend.alu = alu;
         pend.rdd = 32'h0; pend.rd = rd; pend.err = acc;
         return;
      end
      chk("stall_decide", 32'(stall), 32'h1);
      fault = !(ack_at >= 1 && ack_at <= int'(MW));
      nw    = fault ? int'(MW) : ack_at;
      for (int w = 1; w <= nw; w++) begin
         @(posedge clk); #1;
         mem_ack   = (w == ack_at);
         mem_rdata = (w == ack_at) ? rdata : $urandom;
         @(negedge clk);
         chk("stall_wait", 32'(stall), 32'h1);
         chk("req_wait", 32'(mem_req), 32'h1);
         chk("we", 32'(mem_we), 32'(mw));
         chk("addr", mem_addr, alu);
         chk("wdata", mem_wdata, wd);
         chk_bubble("bub_wait");
      end
      @(posedge clk); #1;
      mem_ack   = 1'($urandom % 2);     // spurious in DONE
      mem_rdata = $urandom;
      @(negedge clk);
      chk("stall_done", 32'(stall), 32'h0);
      chk("req_done", 32'(mem_req), 32'h0);
      chk_bubble("bub_done");
      pend.pc = pc; pend.m2r = m2r; pend.rw = rw & ~fault; pend.alu = alu;
      pend.rdd = (mw | fault) ? 32'h0 : rdata; pend.rd = rd; pend.err = fault;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".req"}, 32'(mem_req), 32'h0);
      chk({tag, ".we"}, 32'(mem_we), 32'h0);
      chk({tag, ".addr"}, mem_addr, 32'h0);
      chk({tag, ".wdata"}, mem_wdata, 32'h0);
      chk({tag, ".stall"}, 32'(stall), 32'h0);
      chk_bubble(tag);
   endtask

   initial begin
      logic [31:0] a;
      logic        r, wr;
      int          k;
      rst = 1'b1;
      PC_in = 32'h0; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemtoReg_in = 1'b0;
      RegWrite_in = 1'b0; ALU_output_in = 32'h0; Write_data_in = 32'h0; Rd_in = 5'd0;
      mem_rdata = 32'h0; mem_ack = 1'b0;
      #1;
      chk_reset_vals("rst0");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst1");
      rst = 1'b0;
      pend = '0;

      // Directed cases
      run_instr(32'h400, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 32'h0, 0);
      run_instr(32'h404, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'hdeadbeef, 1);
      run_instr(32'h408, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h55aa55aa, 32'h0, 3);
      run_instr(32'h40c, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 32'h0, 0);
      run_instr(32'h410, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 32'hcafef00d, int'(MW));
      run_instr(32'h414, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 32'h0, 1);
      run_instr(32'h418, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h77, 32'h12345678, 2);
      run_instr(32'h41c, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 32'h0badc0de, 1);

      // Randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         k  = int'($urandom % 4);
         r  = (k == 1) || (k == 3);
         wr = (k == 2) || (k == 3);
         a  = $urandom;
         if ($urandom % 4 != 0) a[1:0] = 2'b00;
         run_instr($urandom, 5'($urandom), r, wr, 1'($urandom), 1'($urandom),
                   a, $urandom, $urandom, int'($urandom_range(0, MW + 1)));
      end
      run_instr(32'h500, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0, 0);

      // Reset during WAIT, then a spurious ack after release
      @(posedge clk); #1;
      PC_in = 32'h600; Rd_in = 5'd2; MemRead_in = 1'b1; MemWrite_in = 1'b0;
      MemtoReg_in = 1'b1; RegWrite_in = 1'b1; ALU_output_in = 32'h80; mem_ack = 1'b0;
      @(negedge clk);
      chk_wb("wb_pre_rst", pend);
      @(posedge clk); #1;
      @(negedge clk);
      chk("req_pre_rst", 32'(mem_req), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk_reset_vals("rst_wait");
      @(posedge clk); #1;
      PC_in = 32'h644; Rd_in = 5'd3; MemRead_in = 1'b0; MemWrite_in = 1'b0;
      MemtoReg_in = 1'b0; RegWrite_in = 1'b1; ALU_output_in = 32'h8;
      mem_ack = 1'b1; mem_rdata = 32'hdeaddead;
      @(negedge clk);
      chk_reset_vals("rst_hold");
      rst = 1'b0;
      #1;
      chk("stall_rel", 32'(stall), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("req_spur", 32'(mem_req), 32'h0);
      chk("stall_spur", 32'(stall), 32'h0);
      pend.pc = 32'h644; pend.m2r = 1'b0; pend.rw = 1'b1; pend.alu = 32'h8;
      pend.rdd = 32'h0; pend.rd = 5'd3; pend.err = 1'b0;
      chk_wb("wb_spur", pend);
      run_instr(32'h700, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h90, 32'h0, 32'h13579bdf, 2);
      run_instr(32'h704, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

MEM-stage controller of the 5-stage pipeline. It consumes the EX/MEM register outputs and drives a handshaked external data memory. It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB state for the write-back stage. Non-memory instructions pass through with one cycle of latency and no stall.

## Interface
- MAX_WAIT, 16, maximum WAIT cycles before an access is abandoned (>=2); counter width is $clog2(MAX_WAIT)+1
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- PC_in  in  32  PC from EX/MEM
- MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in  in  1 each  control bits from EX/MEM
- ALU_output_in  in  32  effective address / ALU result
- Write_data_in  in  32  store data
- Rd_in  in  5  destination register
- mem_req  out  1  memory request, registered, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read, registered
- mem_addr  out  32  word address, registered
- mem_wdata  out  32  store data, registered
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse from memory
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- PC_out  out  32  MEM/WB PC
- MemtoReg_out, RegWrite_out  out  1 each  MEM/WB control bits
- ALU_output_out, Read_data_out  out  32 each  MEM/WB data
- Rd_out  out  5  MEM/WB destination
- mem_err  out  1  one-cycle pulse, aligned with the WB load of a faulted instruction

## Operation
- access = MemRead_in | MemWrite_in; aligned = (ALU_output_in[1:0] == 0).
- MemWrite has priority when both bits are set: mem_we=1 and Read_data_out=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no access: stall=0; MEM/WB loads the inputs; Read_data_out=0.
- IDLE, access, misaligned: no request and stall=0. MEM/WB loads the inputs with RegWrite_out forced 0. mem_err pulses.
- IDLE, access, aligned: stall=1 and the FSM moves to WAIT. Registered outputs: mem_req<=1, mem_we<=MemWrite_in, mem_addr<=ALU_output_in, mem_wdata<=Write_data_in. The wait counter clears.
- WAIT: stall=1 and the counter increments each cycle.
  - On mem_ack=1: mem_req<=0, read data is captured (0 for writes), and the FSM moves to DONE.
  - If no ack arrives and the counter reaches MAX_WAIT-1: mem_req<=0, the access is marked faulted, and the FSM moves to DONE.
- DONE: stall=0, so EX/MEM advances at this edge. MEM/WB loads the held inputs plus the captured read data. On a fault: Read_data_out=0, RegWrite_out=0, and mem_err pulses. The FSM returns to IDLE.
- Bubble: whenever stall=1, MEM/WB loads a bubble at that edge. The bubble is RegWrite_out=0, MemtoReg_out=0, PC_out=32'hffff_ffff, Rd_out=0, and 0 on both data outputs. This prevents duplicate write-backs.
- mem_ack in IDLE or DONE is spurious and ignored.
- EX/MEM inputs are stable while stall=1 (guaranteed upstream); the block does not re-sample them in WAIT.

## Timing
- Reset values:
  - state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; counter 0; mem_err=0.
  - PC_out=32'hffff_ffff; MemtoReg_out=0, RegWrite_out=0; ALU_output_out=0, Read_data_out=0; Rd_out=0.
  - stall=0 while rst is high.
- Non-memory latency: 1 cycle from input to MEM/WB, with no stall.
- Memory latency with ack on the first WAIT cycle:
  - 2 stall cycles (IDLE decision, WAIT); the DONE edge loads MEM/WB.
  - Total 3 cycles to MEM/WB.
- Each additional WAIT cycle without ack adds one stall cycle.
- Timeout: at most MAX_WAIT WAIT cycles. mem_err is high for exactly the cycle after the DONE edge.
- Back-to-back memory instructions: the next instruction is seen in IDLE on the cycle after DONE, with no dead cycle beyond the FSM.
- mem_ack and timeout in the same cycle: the ack wins and there is no error.
- Reset asserted in WAIT: immediate return to reset values; mem_req drops asynchronously and the outstanding access is discarded.

## Test plan
- ALU op with RegWrite_in=1, Rd_in=5, ALU_output_in=32'h1234 -> next cycle RegWrite_out=1, Rd_out=5, ALU_output_out=32'h1234, and stall never 1.
- Load with addr=32'h100 and mem_rdata=32'hdeadbeef acked on the first WAIT cycle -> stall high for 2 cycles, mem_req high 1 cycle, mem_addr=32'h100. After the DONE edge Read_data_out=32'hdeadbeef, and a bubble (PC_out=32'hffff_ffff, RegWrite_out=0) appears during the stall.
- Store with addr=32'h20 and data=32'h55aa55aa acked after 3 WAIT cycles -> mem_we=1, mem_wdata=32'h55aa55aa, stall for 4 cycles, Read_data_out=0.
- Load with no ack, MAX_WAIT=4 -> mem_req drops after 4 WAIT cycles, then mem_err=1 for one cycle with RegWrite_out=0 and Read_data_out=0.
- Load at addr=32'h102 -> no mem_req, stall=0, mem_err pulse, RegWrite_out=0.
- Reset asserted during WAIT, followed by a spurious ack after release -> all outputs at reset values, FSM stays IDLE, and the ack is ignored.
